// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants: PC width, default reset PC and the fetch-redirect FSM state encodings.
package mips_pipe_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_REDIR = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear takes priority over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: sequential PC+step fetch, EX redirect acceptance with a one-cycle
// IF/ID + ID/EX flush and fetch bubble, and a saturating count of accepted redirects.
module pc_redirect_unit
    import mips_pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [PC_W-1:0] PC_STEP  = 32'd1,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [PC_W-1:0]  redir_target,
    output logic             redir_ack,
    output logic [PC_W-1:0]  pc,
    output logic             if_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] redir_count
);

    fetch_state_e    state, state_next;
    logic [PC_W-1:0] pc_next;
    logic            if_valid_next;
    logic            flush_next;

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        if_valid_next = if_valid;
        flush_next    = 1'b0;
        redir_ack     = 1'b0;

        case (state)
            ST_BOOT: begin
                if_valid_next = 1'b1;
                state_next    = ST_RUN;
            end
            ST_RUN: begin
                // A redirect wins over a hazard stall: the stalled instruction is squashed anyway.
                if (redir_valid) begin
                    redir_ack     = 1'b1;
                    pc_next       = redir_target;
                    if_valid_next = 1'b0;
                    flush_next    = 1'b1;
                    state_next    = ST_REDIR;
                end else if (!stall) begin
                    pc_next       = pc + PC_STEP;
                    if_valid_next = 1'b1;
                end
            end
            ST_REDIR: begin
                // Any redir_valid seen now belongs to a squashed instruction and is dropped.
                if_valid_next = 1'b1;
                state_next    = ST_RUN;
            end
            default: begin
                pc_next       = RESET_PC;
                if_valid_next = 1'b0;
                state_next    = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_BOOT;
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            flush_ifid <= 1'b0;
            flush_idex <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            if_valid   <= if_valid_next;
            flush_ifid <= flush_next;
            flush_idex <= flush_next;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_redir_count (
        .clk  (clk),
        .clear(reset),
        .inc  (redir_ack),
        .count(redir_count)
    );

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, counter saturation on a narrow
// instance, and randomized traffic against a behavioural fetch model.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (CNT_W = 16)
    logic        reset, stall, redir_valid;
    logic [31:0] redir_target;
    logic        redir_ack, if_valid, flush_ifid, flush_idex;
    logic [31:0] pc;
    logic [15:0] redir_count;

    // Narrow-counter instance (CNT_W = 2)
    logic        reset2, stall2, redir_valid2;
    logic [31:0] redir_target2;
    logic        redir_ack2, if_valid2, flush_ifid2, flush_idex2;
    logic [31:0] pc2;
    logic [1:0]  redir_count2;

    pc_redirect_unit #(.RESET_PC(32'h0), .PC_STEP(32'd1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
        .redir_target(redir_target), .redir_ack(redir_ack), .pc(pc),
        .if_valid(if_valid), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .redir_count(redir_count)
    );

    pc_redirect_unit #(.RESET_PC(32'h0), .PC_STEP(32'd1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .stall(stall2), .redir_valid(redir_valid2),
        .redir_target(redir_target2), .redir_ack(redir_ack2), .pc(pc2),
        .if_valid(if_valid2), .flush_ifid(flush_ifid2), .flush_idex(flush_idex2),
        .redir_count(redir_count2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of the directed table: inputs applied this cycle, registered outputs
    // expected during this cycle, and the expected combinational ack.
    typedef struct {
        logic        rst, stl, rv;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] pc;
        logic        valid, flush;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic stl, input logic rv,
                                input logic [31:0] tgt, input logic ack, input logic [31:0] epc,
                                input logic valid, input logic flush, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.tgt = tgt;
        v.ack = ack; v.pc = epc; v.valid = valid; v.flush = flush; v.cnt = cnt;
        return v;
    endfunction

    // Behavioural model: tracks "just came out of reset" and "just accepted a
    // redirect" as the two situations in which no redirect can be taken.
    logic [31:0] m_pc;
    logic        m_valid, m_flush;
    int          m_count;
    bit          m_booting, m_squash;

    function automatic bit model_ack(input logic rv);
        return !m_booting && !m_squash && rv;
    endfunction

    task automatic model_edge(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt);
        bit acc;
        acc = model_ack(rv);
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_count = 0;
            m_booting = 1'b1; m_squash = 1'b0;
        end else if (acc) begin
            m_pc = tgt; m_valid = 1'b0; m_flush = 1'b1;
            m_count = (m_count < 65535) ? m_count + 1 : 65535;
            m_booting = 1'b0; m_squash = 1'b1;
        end else if (m_booting || m_squash) begin
            m_valid = 1'b1; m_flush = 1'b0; m_booting = 1'b0; m_squash = 1'b0;
        end else begin
            m_flush = 1'b0;
            if (!stl) begin
                m_pc = m_pc + 32'd1;
                m_valid = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
        reset2 = 1'b1; stall2 = 1'b0; redir_valid2 = 1'b0; redir_target2 = '0;

        //            rst stl rv  tgt            ack pc             v  f  cnt
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0)); // BOOT
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h1,        1, 0, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h2,        1, 0, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h3,        1, 0, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h4,        1, 0, 0));
        vq.push_back(mk(0, 0, 1, 32'h40,       1, 32'h5,        1, 0, 0)); // redirect at pc=5
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h40,       0, 1, 1));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h40,       1, 0, 1));
        vq.push_back(mk(0, 0, 1, 32'h6,        1, 32'h41,       1, 0, 1));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h6,        0, 1, 2));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h6,        1, 0, 2));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h7,        1, 0, 2));
        vq.push_back(mk(0, 1, 0, 32'h0,        0, 32'h8,        1, 0, 2)); // stall at pc=8
        vq.push_back(mk(0, 1, 0, 32'h0,        0, 32'h8,        1, 0, 2));
        vq.push_back(mk(0, 1, 1, 32'h10,       1, 32'h8,        1, 0, 2)); // redirect beats stall
        vq.push_back(mk(0, 1, 1, 32'h99,       0, 32'h10,       0, 1, 3)); // dropped in REDIR
        vq.push_back(mk(0, 0, 1, 32'h20,       1, 32'h10,       1, 0, 3)); // back-to-back
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h20,       0, 1, 4));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h20,       1, 0, 4));
        vq.push_back(mk(0, 0, 1, 32'h30,       1, 32'h21,       1, 0, 4));
        vq.push_back(mk(1, 0, 0, 32'h0,        0, 32'h30,       0, 1, 5)); // reset in REDIR
        vq.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0)); // BOOT ignores stall
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0));
        vq.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h1,       1, 0, 0));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'hFFFF_FFFF, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'hFFFF_FFFF, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 1)); // wrapped

        @(posedge clk); @(posedge clk); #2;
        reset2 = 1'b0;

        foreach (vq[i]) begin
            reset = vq[i].rst; stall = vq[i].stl;
            redir_valid = vq[i].rv; redir_target = vq[i].tgt;
            #1;
            check($sformatf("vec%0d redir_ack", i),   {31'b0, redir_ack},  {31'b0, vq[i].ack});
            check($sformatf("vec%0d pc", i),          pc,                  vq[i].pc);
            check($sformatf("vec%0d if_valid", i),    {31'b0, if_valid},   {31'b0, vq[i].valid});
            check($sformatf("vec%0d flush_ifid", i),  {31'b0, flush_ifid}, {31'b0, vq[i].flush});
            check($sformatf("vec%0d flush_idex", i),  {31'b0, flush_idex}, {31'b0, vq[i].flush});
            check($sformatf("vec%0d redir_count", i), {16'b0, redir_count}, {16'b0, vq[i].cnt});
            @(posedge clk); #2;
        end

        // Narrow counter: five redirects must leave the count stuck at 3.
        for (int k = 0; k < 5; k++) begin
            redir_valid2 = 1'b1; redir_target2 = 32'(k * 4);
            #1;
            check($sformatf("sat%0d redir_ack", k), {31'b0, redir_ack2}, 32'd1);
            @(posedge clk); #2;
            redir_valid2 = 1'b0;
            #1;
            check($sformatf("sat%0d pc", k), pc2, 32'(k * 4));
            check($sformatf("sat%0d redir_count", k), {30'b0, redir_count2},
                  (k + 1 < 3) ? 32'(k + 1) : 32'd3);
            @(posedge clk); #2;
        end

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 3000; n++) begin
            reset        = (n == 0) || ($urandom_range(63) == 0);
            stall        = ($urandom_range(3) == 0);
            redir_valid  = ($urandom_range(3) == 0);
            redir_target = ($urandom_range(15) == 0) ? 32'hFFFF_FFFE : $urandom();
            #1;
            if (n > 0) begin
                check("rand redir_ack", {31'b0, redir_ack}, {31'b0, model_ack(redir_valid)});
                check("rand pc", pc, m_pc);
                check("rand if_valid", {31'b0, if_valid}, {31'b0, m_valid});
                check("rand flush_ifid", {31'b0, flush_ifid}, {31'b0, m_flush});
                check("rand flush_idex", {31'b0, flush_idex}, {31'b0, m_flush});
                check("rand redir_count", {16'b0, redir_count}, 32'(m_count));
            end
            model_edge(reset, stall, redir_valid, redir_target);
            @(posedge clk); #2;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
